spi_target: RTL and testbench

SPI mode-0 target (peripheral) that answers the SPI initiator in `top`, so a synthesized bench can close the SD-card link on-chip: it receives on `sd_mosi`/`sd_clk`/`sd_csn` and drives `sd_miso`. All SPI inputs are oversampled in the single system clock domain. Received bytes are presented on a one-cycle strobe. Transmit bytes come through a one-entry valid/ready holding register, and an idle byte is substituted when that register is empty.

---
 rtl/spi_target_pkg.sv | 26 ++
 rtl/spi_sync.sv | 37 +++
 rtl/spi_target.sv | 180 ++++++++++++++++++
 tb/tb_spi_target.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
`default_nettype none
//============================================================================
// Module   : spi_target_pkg
// Brief    : Shared widths, CRC7 polynomial, default idle byte, FSM states.
// Revision : 1.0
//============================================================================
package spi_target_pkg;

    localparam int                BYTE_W            = 8;
    localparam logic [6:0]        CRC7_POLY         = 7'h09;
    localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'hFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // One MSB-first step of x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
//============================================================================
// Module   : spi_sync
// Brief    : SYNC_STAGES-deep synchronizer with registered-history edge pulses.
// Revision : 1.0
//============================================================================
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;
    logic                   w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_din};
            r_prev  <= w_sync;
        end
    end

    assign w_sync = r_chain[SYNC_STAGES-1];
    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
//============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target oversampled in clk; one-entry TX holding
//            register with idle-byte substitution. Define SPI_TARGET_CRC7_EN
//            to add a running CRC7 over MOSI on the crc7 port.
// Revision : 1.0
//============================================================================
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_active,
`ifdef SPI_TARGET_CRC7_EN
    output logic [6:0]        crc7,
`endif
    output logic              tx_underrun
);

    localparam int                c_CNT_W = $clog2(BYTE_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BYTE_W - 1);

    logic w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic w_mosi;

    state_t r_state, w_state_nxt;
    logic   w_start, w_end, w_load, w_shift, w_sample;

    logic [BYTE_W-1:0]  r_tx_shift;
    logic [BYTE_W-1:0]  r_hold;
    logic               r_hold_full;
    logic               r_underrun;
    logic [BYTE_W-2:0]  r_rx_shift;
    logic [BYTE_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_seen_rise;
    logic [BYTE_W-1:0]  w_load_byte;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (spi_sck),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (spi_csn),
        .o_rise (w_csn_rise),
        .o_fall (w_csn_fall)
    );

    // Same depth as the SCK path so MOSI is aligned with the detected rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mosi_sync <= '0;
        else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_csn_fall) begin
                    w_state_nxt = ACTIVE;
                    w_start     = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_csn_rise) begin
                    w_state_nxt = IDLE;
                    w_end       = 1'b1;
                end else begin
                    w_sample = w_sck_rise;
                    // Byte boundary falls reload; all other falls advance the shifter.
                    if (w_sck_fall) begin
                        if (r_bit_cnt == '0 && r_seen_rise) w_load  = 1'b1;
                        else                               w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_load_byte = r_hold_full ? r_hold : IDLE_BYTE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift  <= '1;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_bit_cnt   <= '0;
            r_seen_rise <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            // Accept only while empty; a load in the same cycle still sees it empty.
            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
            if (w_load) begin
                r_tx_shift <= w_load_byte;
                if (r_hold_full) r_hold_full <= 1'b0;
                else             r_underrun  <= 1'b1;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b1};
            end else if (w_end) begin
                r_tx_shift <= '1;
            end
            if (w_sample) begin
                r_rx_shift  <= {r_rx_shift[BYTE_W-3:0], w_mosi};
                r_bit_cnt   <= r_bit_cnt + c_CNT_W'(1);
                r_seen_rise <= 1'b1;
                if (r_bit_cnt == c_LAST) begin
                    r_rx_data  <= {r_rx_shift, w_mosi};
                    r_rx_valid <= 1'b1;
                end
            end
            if (w_start || w_end) begin
                r_bit_cnt   <= '0;
                r_seen_rise <= 1'b0;
                r_rx_shift  <= '0;
            end
        end
    end

`ifdef SPI_TARGET_CRC7_EN
    logic [6:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_crc <= '0;
        else if (w_start)  r_crc <= '0;
        else if (w_sample) r_crc <= crc7_next(r_crc, w_mosi);
    end
    assign crc7 = r_crc;
`endif

    assign spi_miso     = r_tx_shift[BYTE_W-1];
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign tx_ready     = ~r_hold_full;
    assign frame_active = (r_state == ACTIVE);
    assign tx_underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
//============================================================================
// Module   : tb_spi_target
// Brief    : Randomized SPI frames against a transaction-level model of spi_target.
// Revision : 1.0
//============================================================================
module tb_spi_target;

    localparam int          SYNC   = 2;
    localparam int          HALF   = 10;
    localparam int          SETTLE = SYNC + 4;
    localparam logic [7:0]  IDLE_B = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       frame_active;
    logic       tx_underrun;
`ifdef SPI_TARGET_CRC7_EN
    logic [6:0] crc7;
    logic [6:0] last_crc = 7'h00;
`endif

    int checks = 0;
    int failures = 0;

    // Transaction-level model: current TX byte and bit position, holding register,
    // count of rising edges in the frame, expected RX bytes in order.
    bit         settled = 1'b0;
    bit         m_frame = 1'b0;
    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_cur = 8'hFF;
    int         m_pos = 0;
    int         m_rises = 0;
    logic [7:0] m_rx_acc = 8'h00;
    logic [6:0] m_crc = 7'h00;
    int         exp_underrun = 0;
    int         obs_underrun = 0;
    int         rx_seen = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] obs_miso = 8'h00;
    logic [7:0] rxq[$];
    logic [6:0] crcq[$];
    logic [7:0] exp_rx;
    logic [6:0] exp_crc;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE_B)) dut (
`ifdef SPI_TARGET_CRC7_EN
        .crc7         (crc7),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sck      (spi_sck),
        .spi_csn      (spi_csn),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .frame_active (frame_active),
        .tx_underrun  (tx_underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        return (c[6] ^ b) ? ({c[5:0], 1'b0} ^ 7'h09) : {c[5:0], 1'b0};
    endfunction

    function automatic void m_load();
        if (m_hold_full) begin
            m_cur = m_hold;
            m_hold_full = 1'b0;
        end else begin
            m_cur = IDLE_B;
            exp_underrun++;
        end
        m_pos = 0;
    endfunction

    // Compare process: strobes checked every cycle, steady outputs once settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_underrun) obs_underrun++;
            if (rx_valid) begin
                rx_seen++;
                last_rx = rx_data;
                if (rxq.size() == 0) begin
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_rx  = rxq.pop_front();
                    exp_crc = crcq.pop_front();
                    check("rx_data", 32'(rx_data), 32'(exp_rx));
`ifdef SPI_TARGET_CRC7_EN
                    check("crc7_at_rx_valid", 32'(crc7), 32'(exp_crc));
                    last_crc = crc7;
`endif
                end
            end
            if (settled) begin
                check("miso", 32'(spi_miso), m_frame ? 32'(m_cur[7 - m_pos]) : 32'd1);
                check("tx_ready", 32'(tx_ready), 32'(!m_hold_full));
                check("frame_active", 32'(frame_active), 32'(m_frame));
                check("underrun_count", 32'(obs_underrun), 32'(exp_underrun));
                check("rx_pending", 32'(rxq.size()), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick(SETTLE);
        settled = 1'b1;
    endtask

    task automatic offer(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid    = 1'b0;
        m_hold      = d;
        m_hold_full = 1'b1;
    endtask

    // coincide: offer d on exactly the clock that performs the csn-fall load.
    task automatic csn_fall(input bit coincide, input logic [7:0] d);
        settled = 1'b0;
        spi_csn = 1'b0;
        m_frame = 1'b1;
        m_rises = 0;
        m_crc   = 7'h00;
        m_load();
        if (coincide) begin
            tick(SYNC);
            tx_data  = d;
            tx_valid = 1'b1;
            tick(1);
            tx_valid    = 1'b0;
            m_hold      = d;
            m_hold_full = 1'b1;
            tick(SETTLE - SYNC - 1);
            settled = 1'b1;
        end else begin
            settle();
        end
        tick(HALF - SETTLE);
    endtask

    task automatic csn_rise();
        settled = 1'b0;
        spi_csn = 1'b1;
        m_frame = 1'b0;
        m_rises = 0;
        settle();
        tick(HALF - SETTLE);
    endtask

    task automatic sck_bit(input logic b, input bit offer_ok);
        spi_mosi = b;
        tick(2);
        obs_miso = {obs_miso[6:0], spi_miso};
        settled  = 1'b0;
        spi_sck  = 1'b1;
        m_rx_acc = {m_rx_acc[6:0], b};
        m_crc    = crc_step(m_crc, b);
        m_rises++;
        if (m_rises % 8 == 0) begin
            rxq.push_back(m_rx_acc);
            crcq.push_back(m_crc);
        end
        settle();
        if (offer_ok && !m_hold_full && $urandom_range(0, 2) == 0)
            offer(8'($urandom_range(0, 255)));
        else
            tick(1);
        tick(HALF - SETTLE - 1);
        settled = 1'b0;
        spi_sck = 1'b0;
        if (m_rises % 8 == 0) m_load();
        else                  m_pos++;
        settle();
        tick(HALF - SETTLE - 2);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit offer_ok);
        for (int i = 7; i >= 0; i--) sck_bit(d[i], offer_ok);
    endtask

    initial begin
        int rx0;
        int u0;
        logic [7:0] b1;

        tick(3);
        check("reset_miso", 32'(spi_miso), 32'd1);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_frame_active", 32'(frame_active), 32'd0);
        check("reset_tx_underrun", 32'(tx_underrun), 32'd0);
`ifdef SPI_TARGET_CRC7_EN
        check("reset_crc7", 32'(crc7), 32'd0);
`endif
        rst_n = 1'b1;
        settle();

        // Preloaded A5 answered while 3C is received.
        offer(8'hA5);
        rx0 = rx_seen;
        csn_fall(1'b0, 8'h00);
        send_byte(8'h3C, 1'b0);
        check("a_miso_byte", 32'(obs_miso), 32'hA5);
        csn_rise();
        check("a_rx_data", 32'(last_rx), 32'h3C);
        check("a_rx_count", 32'(rx_seen - rx0), 32'd1);

        // Two bytes, one preloaded: second byte is the idle byte.
        offer(8'h5A);
        rx0 = rx_seen;
        u0  = obs_underrun;
        csn_fall(1'b0, 8'h00);
        send_byte(8'hC7, 1'b0);
        b1 = obs_miso;
        check("b_underrun_first_byte", 32'(obs_underrun - u0), 32'd1);
        send_byte(8'h19, 1'b0);
        csn_rise();
        check("b_miso_byte0", 32'(b1), 32'h5A);
        check("b_miso_byte1", 32'(obs_miso), 32'hFF);
        check("b_rx_count", 32'(rx_seen - rx0), 32'd2);

        // Frame aborted after five bits, then a clean 81.
        rx0 = rx_seen;
        csn_fall(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) sck_bit(1'($urandom_range(0, 1)), 1'b0);
        csn_rise();
        check("c_partial_no_rx", 32'(rx_seen - rx0), 32'd0);
        csn_fall(1'b0, 8'h00);
        send_byte(8'h81, 1'b0);
        csn_rise();
        check("c_rx_data", 32'(last_rx), 32'h81);

        // Offer lands on the load cycle: idle byte now, 11 next.
        csn_fall(1'b1, 8'h11);
        send_byte(8'h00, 1'b0);
        b1 = obs_miso;
        send_byte(8'h00, 1'b0);
        csn_rise();
        check("d_miso_byte0", 32'(b1), 32'hFF);
        check("d_miso_byte1", 32'(obs_miso), 32'h11);

`ifdef SPI_TARGET_CRC7_EN
        csn_fall(1'b0, 8'h00);
        send_byte(8'h40, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        check("crc_model_cmd0", 32'(m_crc), 32'h4A);
        csn_rise();
        check("crc_cmd0", 32'(last_crc), 32'h4A);
`endif

        // Randomized frames, partial trailing bytes and offers.
        for (int f = 0; f < 12; f++) begin
            if (!m_hold_full && $urandom_range(0, 1) == 1) offer(8'($urandom_range(0, 255)));
            csn_fall(1'b0, 8'h00);
            for (int n = 0; n < int'($urandom_range(1, 3)); n++)
                send_byte(8'($urandom_range(0, 255)), 1'b1);
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < int'($urandom_range(1, 7)); i++)
                    sck_bit(1'($urandom_range(0, 1)), 1'b1);
            csn_rise();
        end

        // Reset in the middle of a frame with the holding register full.
        csn_fall(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) sck_bit(1'b1, 1'b0);
        if (!m_hold_full) offer(8'h77);
        settled = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_miso", 32'(spi_miso), 32'd1);
        check("midreset_tx_ready", 32'(tx_ready), 32'd1);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_frame_active", 32'(frame_active), 32'd0);
        check("midreset_tx_underrun", 32'(tx_underrun), 32'd0);
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        m_frame = 1'b0;
        m_hold_full = 1'b0;
        m_rises = 0;
        m_pos = 0;
        exp_underrun = 0;
        obs_underrun = 0;
        rxq.delete();
        crcq.delete();
        tick(2);
        rst_n = 1'b1;
        settle();
        csn_fall(1'b0, 8'h00);
        send_byte(8'hC3, 1'b0);
        csn_rise();
        check("post_reset_miso", 32'(obs_miso), 32'hFF);
        check("post_reset_rx", 32'(last_rx), 32'hC3);

        check("final_rx_pending", 32'(rxq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
